// File: rtl/bin2bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_pkg -- shared definitions for the sequential binary-to-BCD converter.
//   state_e     : converter FSM states (IDLE, SHIFT, DONE)
//   DIGIT_W     : width of one BCD digit
//   min_digits  : smallest digit count D with 10^D >= 2^W
// ---------------------------------------------------------------------------
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DIGIT_W = 4;

  // 64-bit arithmetic so that 2^32 is representable for W = 32.
  function automatic int min_digits(input int w);
    logic [63:0] lim;
    logic [63:0] p;
    int          d;
    lim = 64'd1 << w;
    p   = 64'd1;
    d   = 0;
    for (int i = 0; i < 20; i++) begin
      if (p < lim) begin
        p = p * 64'd10;
        d = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3 -- one double-dabble digit-correction cell (combinational).
//   digit_i [3:0] : scratch digit before the shift
//   digit_o [3:0] : digit + 3 when digit >= 5, otherwise unchanged
// ---------------------------------------------------------------------------
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq -- sequential shift-add-3 (double dabble) binary to BCD converter.
// One input bit is processed per clock; a W-bit operand takes W SHIFT cycles.
//
// Parameters
//   W  : binary input width (4..32)
//   D  : BCD digit count, must satisfy 10^D >= 2^W
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : bin holds an operand
//   in_ready   : converter accepts an operand this cycle (IDLE only)
//   bin  [W]   : unsigned operand, sampled on accept
//   out_valid  : bcd holds a finished result (DONE only)
//   out_ready  : consumer takes the result this cycle
//   bcd  [4*D] : packed BCD result, digit 0 in bits [3:0]
//   busy       : converter is not IDLE
//   blank [D]  : (only with BIN2BCD_SEQ_BLANK_EN) leading-zero flags;
//                blank[i]=1 when digit i and all higher digits are 0, i>0
// Optional feature macro: BIN2BCD_SEQ_BLANK_EN
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         bin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIGIT_W*D-1:0] bcd,
  output logic                 busy
`ifdef BIN2BCD_SEQ_BLANK_EN
  ,
  output logic [D-1:0]         blank
`endif
);

  localparam int CNT_W = $clog2(W + 1);
  localparam int BCD_W = DIGIT_W * D;

  if (W < 4 || W > 32) begin : g_bad_w
    $error("bin2bcd_seq: W=%0d outside 4..32", W);
  end
  if (D < min_digits(W)) begin : g_bad_d
    $error("bin2bcd_seq: D=%0d too small for W=%0d (need %0d)", D, W, min_digits(W));
  end

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     opd_q, opd_d;
  logic [BCD_W-1:0] scr_q, scr_d;
  logic [BCD_W-1:0] corr;
  logic [BCD_W-1:0] bcd_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  // Per-digit +3 correction applied before every shift.
  for (genvar g = 0; g < D; g++) begin : g_digit
    bcd_add3 u_add3 (
      .digit_i (scr_q[g*DIGIT_W +: DIGIT_W]),
      .digit_o (corr[g*DIGIT_W +: DIGIT_W])
    );
  end

  // {scratch, operand} << 1: the operand MSB enters scratch bit 0. The corrected
  // top bit that falls off is always 0 once D is large enough for W.
  assign scr_d = BCD_W'({corr, opd_q[W-1]});
  assign opd_d = {opd_q[W-2:0], 1'b0};
  assign cnt_d = cnt_q - CNT_W'(1);

`ifdef BIN2BCD_SEQ_BLANK_EN
  logic [D-1:0] blank_q, blank_d;
  logic         zero_hi;

  // Computed on the value about to be latched, so blank moves with bcd.
  always_comb begin
    blank_d = '0;
    zero_hi = 1'b1;
    for (int i = D - 1; i >= 1; i--) begin
      zero_hi    = zero_hi & (scr_d[i*DIGIT_W +: DIGIT_W] == 4'd0);
      blank_d[i] = zero_hi;
    end
  end

  assign blank = blank_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      opd_q       <= '0;
      scr_q       <= '0;
      bcd_q       <= '0;
`ifdef BIN2BCD_SEQ_BLANK_EN
      blank_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            opd_q      <= bin;
            scr_q      <= '0;
            cnt_q      <= CNT_W'(W);
            state_q    <= SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          scr_q <= scr_d;
          opd_q <= opd_d;
          cnt_q <= cnt_d;
          // Last bit shifted in: the result is final on this edge.
          if (cnt_d == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            bcd_q       <= scr_d;
`ifdef BIN2BCD_SEQ_BLANK_EN
            blank_q     <= blank_d;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign bcd       = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq -- directed bench for bin2bcd_seq (W=8/D=3 and W=16/D=5).
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  bin;
  logic [11:0] bcd;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0] bin16;
  logic [19:0] bcd16;

`ifdef BIN2BCD_SEQ_BLANK_EN
  logic [2:0]  blank8;
  logic [4:0]  blank16;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  bin2bcd_seq #(.W(8), .D(3)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .busy      (busy)
`ifdef BIN2BCD_SEQ_BLANK_EN
    ,
    .blank     (blank8)
`endif
  );

  bin2bcd_seq #(.W(16), .D(5)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .bin       (bin16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .bcd       (bcd16),
    .busy      (busy16)
`ifdef BIN2BCD_SEQ_BLANK_EN
    ,
    .blank     (blank16)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref8(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Accept b, wait for the result, check it, then hand it off.
  task automatic conv8(input string tag, input logic [7:0] b, input logic [11:0] exp,
                       input bit hold);
    int n;
    out_ready = hold;
    in_valid  = 1'b1;
    bin       = b;
    tick();
    in_valid  = 1'b0;
    bin       = ~b;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".irdy_lo"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, ".lat"}, n, 32'd8);
    chk({tag, ".bcd"}, 32'(bcd), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".ovld_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".irdy_back"}, 32'(in_ready), 32'd1);
    chk({tag, ".bcd_hold"}, 32'(bcd), 32'(exp));
  endtask

  initial begin
    int n;
    int seen;
    int acc;
    int prev;

    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    bin         = '0;
    in_valid16  = 1'b0;
    out_ready16 = 1'b0;
    bin16       = '0;

    // Reset state
    tick();
    tick();
    chk("rst.irdy", 32'(in_ready), 32'd1);
    chk("rst.ovld", 32'(out_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.bcd", 32'(bcd), 32'd0);
    chk("rst.bcd16", 32'(bcd16), 32'd0);
    rst = 1'b0;
    tick();

    // Basic conversions
    conv8("zero", 8'd0, 12'h000, 1'b0);
    conv8("max", 8'd255, 12'h255, 1'b1);
    conv8("hundred", 8'd100, 12'h100, 1'b1);

    // Backpressure with in_valid pulses while DONE
    in_valid = 1'b1;
    bin      = 8'd37;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("bp.lat", n, 32'd8);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      bin      = 8'd200;
      tick();
      chk("bp.bcd", 32'(bcd), 32'h037);
      chk("bp.ovld", 32'(out_valid), 32'd1);
      chk("bp.irdy", 32'(in_ready), 32'd0);
    end
`ifdef BIN2BCD_SEQ_BLANK_EN
    chk("bp.blank", 32'(blank8), 32'b100);
`endif
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp.irdy_back", 32'(in_ready), 32'd1);
    chk("bp.ovld_drop", 32'(out_valid), 32'd0);

    // Reset on the 4th SHIFT cycle of 199
    in_valid = 1'b1;
    bin      = 8'd199;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.irdy", 32'(in_ready), 32'd1);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.bcd", 32'(bcd), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort.no_ovld", seen, 32'd0);
    conv8("after_abort", 8'd42, 12'h042, 1'b0);

    // Reset in DONE, together with an out handshake
    in_valid = 1'b1;
    bin      = 8'd77;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("done77.bcd", 32'(bcd), 32'h077);
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    chk("rst_done.ovld", 32'(out_valid), 32'd0);
    chk("rst_done.bcd", 32'(bcd), 32'd0);

    // Reset wins over a simultaneous accept
    rst      = 1'b1;
    in_valid = 1'b1;
    bin      = 8'd5;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_pri.busy", 32'(busy), 32'd0);
    chk("rst_pri.irdy", 32'(in_ready), 32'd1);

    // W=16, D=5
    in_valid16 = 1'b1;
    bin16      = 16'd65535;
    tick();
    in_valid16 = 1'b0;
    bin16      = 16'd1;
    n = 0;
    while (!out_valid16 && n < 60) begin
      tick();
      n++;
    end
    chk("w16.lat", n, 32'd16);
    chk("w16.max", 32'(bcd16), 32'h65535);
`ifdef BIN2BCD_SEQ_BLANK_EN
    chk("w16.blank_max", 32'(blank16), 32'd0);
`endif
    out_ready16 = 1'b1;
    tick();
    out_ready16 = 1'b0;
    in_valid16  = 1'b1;
    bin16       = 16'd9;
    tick();
    in_valid16  = 1'b0;
    n = 0;
    while (!out_valid16 && n < 60) begin
      tick();
      n++;
    end
    chk("w16.nine", 32'(bcd16), 32'h00009);
`ifdef BIN2BCD_SEQ_BLANK_EN
    chk("w16.blank_nine", 32'(blank16), 32'b11110);
`endif
    out_ready16 = 1'b1;
    tick();
    out_ready16 = 1'b0;

    // Back-to-back sweep 0..255
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prev      = 0;
    for (int v = 0; v < 256; v++) begin
      bin = 8'(v);
      n = 0;
      while (!in_ready && n < 20) begin
        tick();
        n++;
      end
      tick();
      acc = cyc;
      bin = 8'(v) ^ 8'hA5;
      if (v > 0) chk("sweep.space", acc - prev, 32'd10);
      prev = acc;
      n = 0;
      while (!out_valid && n < 40) begin
        tick();
        n++;
      end
      chk($sformatf("sweep.bcd[%0d]", v), 32'(bcd), 32'(ref8(v)));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
